// File: rtl/addertest_pkg.sv
// Shared types and helpers for the sequenced a/b accumulation chain.
package addertest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_MAX_STEPS = 10;

  // Map a raw step request onto the legal range 1..max_steps (0 means a single step).
  function automatic int unsigned clamp_steps(input int unsigned raw,
                                              input int unsigned max_steps = DEFAULT_MAX_STEPS);
    if (raw == 0) begin
      return 1;
    end else if (raw > max_steps) begin
      return max_steps;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/addertest_seq_if.sv
// Operand/result handshake bundle between source, sequencer and sink.
interface addertest_seq_if #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [STEP_W-1:0] cfg_steps;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_sum;
  logic              busy;

  modport master (
    output in_valid, in_a, in_b, cfg_steps, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, cfg_steps, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/addertest_step_alu.sv
// The single shared adder with its operand mux: fresh operands in IDLE,
// accumulator plus the alternating latched operand while running.
module addertest_step_alu
  import addertest_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  state_t           state,
  input  logic             cnt_odd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a_lat,
  input  logic [WIDTH-1:0] b_lat,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;

  // Select adder operands; odd steps add a, even steps add b.
  always_comb begin
    op_x = in_a;
    op_y = in_b;
    if (state == ST_RUN) begin
      op_x = acc;
      op_y = cnt_odd ? a_lat : b_lat;
    end
  end

  // Carry-out is intentionally dropped: arithmetic is modulo 2^WIDTH.
  assign sum = op_x + op_y;

endmodule

// File: rtl/addertest_seq.sv
// Multi-cycle sequencer: accepts (a, b, N), runs N accumulate steps through
// one shared adder, then holds the result until the sink takes it.
module addertest_seq
  import addertest_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_STEPS = DEFAULT_MAX_STEPS,
  parameter int STEP_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  addertest_seq_if.slave bus
);

  state_t            state_q;
  state_t            state_nxt;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [STEP_W-1:0] cnt_q;
  logic [STEP_W-1:0] n_q;
  logic [STEP_W-1:0] n_in;
  logic [STEP_W-1:0] cnt_inc;
  logic [WIDTH-1:0]  alu_sum;
  logic              accept;

  assign n_in    = STEP_W'(clamp_steps(int'(unsigned'(bus.cfg_steps)), MAX_STEPS));
  assign cnt_inc = cnt_q + STEP_W'(1);
  assign accept  = (state_q == ST_IDLE) && bus.in_valid;

  addertest_step_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .state  (state_q),
    .cnt_odd(cnt_q[0]),
    .in_a   (bus.in_a),
    .in_b   (bus.in_b),
    .acc    (acc_q),
    .a_lat  (a_q),
    .b_lat  (b_q),
    .sum    (alu_sum)
  );

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode: IDLE -> RUN/DONE on accept, RUN -> DONE on last step,
  // DONE -> IDLE on output handshake.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_nxt = (n_in == STEP_W'(1)) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_inc == n_q) state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, step counter and accumulator; acc holds steady in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      n_q   <= '0;
    end else if (accept) begin
      a_q   <= bus.in_a;
      b_q   <= bus.in_b;
      n_q   <= n_in;
      acc_q <= alu_sum;
      cnt_q <= STEP_W'(1);
    end else if (state_q == ST_RUN) begin
      acc_q <= alu_sum;
      cnt_q <= cnt_inc;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_sum   = acc_q;

endmodule

// File: tb/tb_addertest_seq.sv
// Bench for addertest_seq: scoreboard of expected sums/latencies pushed at
// accept and popped when the result appears.
module tb_addertest_seq;

  localparam int WIDTH     = 32;
  localparam int STEP_W    = 4;
  localparam int MAX_STEPS = 10;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  addertest_seq_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  addertest_seq #(
    .WIDTH    (WIDTH),
    .MAX_STEPS(MAX_STEPS),
    .STEP_W   (STEP_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] exp_sum_q[$];
  int               exp_lat_q[$];

  function automatic int model_n(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > MAX_STEPS) return MAX_STEPS;
    return cfg;
  endfunction

  // Closed form: (1+ceil((N-1)/2))*a + (1+floor((N-1)/2))*b mod 2^32.
  function automatic logic [WIDTH-1:0] model_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input int cfg);
    int n;
    logic [WIDTH-1:0] ka, kb;
    n  = model_n(cfg);
    ka = WIDTH'(1 + n / 2);
    kb = WIDTH'(1 + (n - 1) / 2);
    return ka * a + kb * b;
  endfunction

  // Offer a job and wait for the accept edge; called #1 after a clock edge.
  task automatic accept_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input int cfg, output bit ok);
    int waited = 0;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.cfg_steps = STEP_W'(cfg);
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=%b required=1", bus.in_ready);
      bus.in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    exp_sum_q.push_back(model_sum(a, b, cfg));
    exp_lat_q.push_back(model_n(cfg));
    #1;
    bus.in_valid = 1'b0;
    ok = 1'b1;
  endtask

  // Wait for the result, check sum and latency, complete the handshake.
  task automatic collect_job(input string name, input bit scramble);
    int lat = 1;
    logic [WIDTH-1:0] exp_sum;
    int exp_lat;
    while (!bus.out_valid && lat < 100) begin
      if (scramble) begin
        bus.in_a      = $urandom;
        bus.in_b      = $urandom;
        bus.cfg_steps = STEP_W'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (bus.out_valid !== 1'b1 || exp_sum_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_out_valid_timeout: out_valid=%b required=1 (queued=%0d)",
               name, bus.out_valid, exp_sum_q.size());
      return;
    end
    exp_sum = exp_sum_q.pop_front();
    exp_lat = exp_lat_q.pop_front();
    tests_run++;
    if (bus.out_sum !== exp_sum) begin
      tests_failed++;
      $display("FAIL %s_sum: got 0x%08h required 0x%08h", name, bus.out_sum, exp_sum);
    end
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, exp_lat);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_return_idle: out_valid=%b in_ready=%b busy=%b required 0/1/0",
               name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.cfg_steps = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b out_sum=0x%08h required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_sum);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    accept_job(32'd1, 32'd2, 10, ok);          if (ok) collect_job("n10_16", 1'b0);
    accept_job(32'hFFFF_FFFF, 32'd1, 10, ok);  if (ok) collect_job("n10_wrap", 1'b0);
    accept_job(32'd3, 32'd4, 1, ok);           if (ok) collect_job("n1_7", 1'b0);
    accept_job(32'd3, 32'd4, 2, ok);           if (ok) collect_job("n2_10", 1'b0);
  endtask

  task automatic test_clamp();
    bit ok;
    accept_job(32'd3, 32'd4, 0, ok);   if (ok) collect_job("cfg0_as_1", 1'b0);
    accept_job(32'd1, 32'd2, 15, ok);  if (ok) collect_job("cfg15_clamp", 1'b0);
  endtask

  task automatic test_input_scramble();
    bit ok;
    accept_job(32'h1234_5678, 32'h0BAD_F00D, 10, ok);
    if (ok) collect_job("scramble_n10", 1'b1);
    accept_job(32'h8000_0001, 32'h7FFF_FFFF, 7, ok);
    if (ok) collect_job("scramble_n7", 1'b1);
  endtask

  task automatic test_backpressure();
    bit ok;
    int waited = 0;
    logic [WIDTH-1:0] exp_sum;
    bus.out_ready = 1'b0;
    accept_job(32'd5, 32'd7, 3, ok);
    if (!ok) begin
      bus.out_ready = 1'b1;
      return;
    end
    while (!bus.out_valid && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    exp_sum = exp_sum_q.pop_front();
    void'(exp_lat_q.pop_front());
    // A pending job is offered while the result is being held back.
    bus.in_a      = 32'd1;
    bus.in_b      = 32'd1;
    bus.cfg_steps = STEP_W'(1);
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: out_valid=%b out_sum=0x%08h in_ready=%b required 1/0x%08h/0",
                 i, bus.out_valid, bus.out_sum, bus.in_ready, exp_sum);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_idle: out_valid=%b in_ready=%b required 0/1",
               bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    exp_sum_q.push_back(model_sum(32'd1, 32'd1, 1));
    exp_lat_q.push_back(model_n(1));
    #1;
    bus.in_valid = 1'b0;
    collect_job("bp_pending", 1'b0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 6; i++) begin
      accept_job($urandom, $urandom, $urandom_range(0, 15), ok);
      if (ok) collect_job($sformatf("b2b_%0d", i), 1'b0);
    end
  endtask

  task automatic test_midjob_reset();
    bit ok;
    accept_job(32'd9, 32'd3, 10, ok);
    if (ok) begin
      exp_sum_q.delete();
      exp_lat_q.delete();
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.out_sum !== '0) begin
        tests_failed++;
        $display("FAIL midjob_reset: in_ready=%b out_valid=%b busy=%b out_sum=0x%08h required 1/0/0/0",
                 bus.in_ready, bus.out_valid, bus.busy, bus.out_sum);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_idle: out_valid=%b busy=%b required 0/0",
                 bus.out_valid, bus.busy);
      end
    end
    accept_job(32'd2, 32'd2, 10, ok);
    if (ok) collect_job("after_reset_22", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_input_scramble();
    test_backpressure();
    test_back_to_back();
    test_midjob_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
